// File: rtl/dcache_write_buffer.sv
// Merging write-back buffer between DCache stage 2 and the AXI write port.
// Line entries merge byte-wise until they reach the head and start draining, then retire in FIFO order.
module dcache_write_buffer #(
  parameter int DEPTH      = 8,
  parameter int LINE_BYTES = 32,
  parameter int ADDR_W     = 32
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_wb_valid,
  output logic                         o_wb_ready,
  input  logic [ADDR_W-1:0]            i_wb_addr,
  input  logic [8*LINE_BYTES-1:0]      i_wb_data,
  input  logic [LINE_BYTES-1:0]        i_wb_strb,
  output logic                         o_dca_write_able,
  input  logic                         i_dw_shankhand,
  output logic [ADDR_W-1:0]            o_dca_write_addr,
  output logic [8*LINE_BYTES-1:0]      o_dca_w_date,
  output logic [LINE_BYTES-1:0]        o_dca_w_strb,
  input  logic [ADDR_W-1:0]            i_lookup_addr,
  output logic                         o_lookup_hit,
  output logic [8*LINE_BYTES-1:0]      o_lookup_data,
  output logic [LINE_BYTES-1:0]        o_lookup_strb,
  input  logic                         i_flush_req,
  output logic                         o_flush_done,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic                         o_full,
  output logic                         o_empty
);

  localparam int LW    = 8 * LINE_BYTES;
  localparam int OFF_W = $clog2(LINE_BYTES);
  localparam int LA_W  = ADDR_W - OFF_W;
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {E_FREE, E_VALID, E_DRAIN} ent_state_t;
  typedef enum logic {D_IDLE, D_ISSUE} drain_state_t;

  ent_state_t           r_state [DEPTH];
  logic [LA_W-1:0]      r_line  [DEPTH];
  logic [LW-1:0]        r_data  [DEPTH];
  logic [LINE_BYTES-1:0] r_strb [DEPTH];

  logic [PW-1:0]        r_head;
  logic [PW-1:0]        r_tail;
  logic [CW-1:0]        r_count;
  drain_state_t         r_dstate;
  drain_state_t         w_dstate_next;
  logic                 r_flush_armed;

  logic [LA_W-1:0]      w_wb_line;
  logic [LA_W-1:0]      w_lk_line;
  logic [LW-1:0]        w_wb_bmask;
  logic [DEPTH-1:0]     w_wb_hit;
  logic [DEPTH-1:0]     w_lk_valid;
  logic [DEPTH-1:0]     w_lk_drain;
  logic [PW-1:0]        w_merge_idx;
  logic [PW-1:0]        w_lk_v_idx;
  logic [PW-1:0]        w_lk_d_idx;
  logic [PW-1:0]        w_lk_idx;
  logic                 w_merge_hit;
  logic                 w_do_merge;
  logic                 w_do_alloc;
  logic                 w_start;
  logic                 w_retire;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_unused;

  assign w_wb_line = i_wb_addr[ADDR_W-1:OFF_W];
  assign w_lk_line = i_lookup_addr[ADDR_W-1:OFF_W];
  assign w_unused  = ^{i_wb_addr[OFF_W-1:0], i_lookup_addr[OFF_W-1:0]};

  genvar gi;
  generate
    for (gi = 0; gi < LINE_BYTES; gi++) begin : g_bmask
      assign w_wb_bmask[8*gi +: 8] = {8{i_wb_strb[gi]}};
    end
    for (gi = 0; gi < DEPTH; gi++) begin : g_match
      assign w_wb_hit[gi]   = (r_state[gi] == E_VALID) && (r_line[gi] == w_wb_line);
      assign w_lk_valid[gi] = (r_state[gi] == E_VALID) && (r_line[gi] == w_lk_line);
      assign w_lk_drain[gi] = (r_state[gi] == E_DRAIN) && (r_line[gi] == w_lk_line);
    end
  endgenerate

  // At most one VALID entry per line, so a priority scan yields the unique match.
  always_comb begin
    w_merge_idx = '0;
    w_lk_v_idx  = '0;
    w_lk_d_idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_wb_hit[i])   w_merge_idx = PW'(i);
      if (w_lk_valid[i]) w_lk_v_idx  = PW'(i);
      if (w_lk_drain[i]) w_lk_d_idx  = PW'(i);
    end
  end

  assign w_merge_hit = |w_wb_hit;
  assign w_full      = (r_count == CW'(DEPTH));
  assign w_empty     = (r_count == '0);
  assign w_do_merge  = i_wb_valid & w_merge_hit;
  assign w_do_alloc  = i_wb_valid & ~w_merge_hit & ~w_full & ~i_flush_req & (|i_wb_strb);

  assign o_wb_ready  = w_merge_hit | (~w_full & ~i_flush_req);
  assign o_count     = r_count;
  assign o_full      = w_full;
  assign o_empty     = w_empty;
  assign o_flush_done = i_flush_req & w_empty & r_flush_armed;

  // Newer VALID copy wins over the line currently being written out.
  always_comb begin
    o_lookup_hit  = (|w_lk_valid) | (|w_lk_drain);
    w_lk_idx      = (|w_lk_valid) ? w_lk_v_idx : w_lk_d_idx;
    o_lookup_data = '0;
    o_lookup_strb = '0;
    if (o_lookup_hit) begin
      o_lookup_data = r_data[w_lk_idx];
      o_lookup_strb = r_strb[w_lk_idx];
    end
  end

  always_comb begin
    w_dstate_next = r_dstate;
    w_start       = 1'b0;
    w_retire      = 1'b0;
    case (r_dstate)
      D_IDLE: begin
        if (r_state[r_head] == E_VALID) begin
          w_start       = 1'b1;
          w_dstate_next = D_ISSUE;
        end
      end
      D_ISSUE: begin
        if (i_dw_shankhand) begin
          w_retire      = 1'b1;
          w_dstate_next = D_IDLE;
        end
      end
      default: w_dstate_next = D_IDLE;
    endcase
  end

  assign o_dca_write_able = (r_dstate == D_ISSUE);
  assign o_dca_write_addr = o_dca_write_able ? {r_line[r_head], {OFF_W{1'b0}}} : '0;
  assign o_dca_w_date     = o_dca_write_able ? r_data[r_head] : '0;
  assign o_dca_w_strb     = o_dca_write_able ? r_strb[r_head] : '0;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) r_state[i] <= E_FREE;
      r_head        <= '0;
      r_tail        <= '0;
      r_count       <= '0;
      r_dstate      <= D_IDLE;
      r_flush_armed <= 1'b1;
    end else begin
      r_dstate <= w_dstate_next;
      if (w_start) r_state[r_head] <= E_DRAIN;
      if (w_retire) begin
        r_state[r_head] <= E_FREE;
        r_head          <= r_head + 1'b1;
      end
      if (w_do_alloc) begin
        r_state[r_tail] <= E_VALID;
        r_tail          <= r_tail + 1'b1;
      end
      r_count <= r_count + CW'(w_do_alloc) - CW'(w_retire);
      if (!i_flush_req)      r_flush_armed <= 1'b1;
      else if (o_flush_done) r_flush_armed <= 1'b0;
    end
  end

  // Payload needs no reset; entry state gates every use of it.
  always_ff @(posedge i_clk) begin
    if (w_do_alloc) begin
      r_line[r_tail] <= w_wb_line;
      r_data[r_tail] <= i_wb_data & w_wb_bmask;
      r_strb[r_tail] <= i_wb_strb;
    end else if (w_do_merge) begin
      r_data[w_merge_idx] <= (r_data[w_merge_idx] & ~w_wb_bmask) | (i_wb_data & w_wb_bmask);
      r_strb[w_merge_idx] <= r_strb[w_merge_idx] | i_wb_strb;
    end
  end

endmodule

// File: tb/tb_dcache_write_buffer.sv
// Bench for dcache_write_buffer: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then a randomized phase.
module tb_dcache_write_buffer;
  localparam int DEPTH = 8;
  localparam int LB    = 32;
  localparam int AW    = 32;
  localparam int LW    = 256;
  localparam int OFF   = 5;
  localparam int LAW   = AW - OFF;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            wb_valid, wb_ready, hs, able, lk_hit, flush, fdone, full, empty;
  logic [AW-1:0]   wb_addr, wr_addr, lk_addr;
  logic [LW-1:0]   wb_data, wr_data, lk_data;
  logic [LB-1:0]   wb_strb, wr_strb, lk_strb;
  logic [3:0]      count;

  always #5 clk = ~clk;

  dcache_write_buffer #(.DEPTH(DEPTH), .LINE_BYTES(LB), .ADDR_W(AW)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_wb_valid(wb_valid), .o_wb_ready(wb_ready), .i_wb_addr(wb_addr),
    .i_wb_data(wb_data), .i_wb_strb(wb_strb),
    .o_dca_write_able(able), .i_dw_shankhand(hs), .o_dca_write_addr(wr_addr),
    .o_dca_w_date(wr_data), .o_dca_w_strb(wr_strb),
    .i_lookup_addr(lk_addr), .o_lookup_hit(lk_hit), .o_lookup_data(lk_data),
    .o_lookup_strb(lk_strb),
    .i_flush_req(flush), .o_flush_done(fdone),
    .o_count(count), .o_full(full), .o_empty(empty)
  );

  typedef struct {
    logic [LAW-1:0] line;
    logic [LW-1:0]  data;
    logic [LB-1:0]  strb;
  } ent_t;

  ent_t mq[$];
  bit   m_issuing = 0;
  bit   m_armed   = 1;
  int   n_checks  = 0;
  int   n_errors  = 0;
  int   done_cnt  = 0;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [LW-1:0] bmask(input logic [LB-1:0] s);
    logic [LW-1:0] m;
    for (int b = 0; b < LB; b++) m[8*b +: 8] = {8{s[b]}};
    return m;
  endfunction

  // Reference model: FIFO of line entries; the front may be the one being written out.
  always @(negedge clk) begin
    int sz, mi, li;
    logic [LAW-1:0] wl, ll;
    logic ex_ready, ex_done;
    logic [LW-1:0] m;
    ent_t e;
    if (rst) begin
      mq.delete();
      m_issuing = 0;
      m_armed   = 1;
      chk("rst_able",  LW'(able),     LW'(0));
      chk("rst_count", LW'(count),    LW'(0));
      chk("rst_empty", LW'(empty),    LW'(1));
      chk("rst_full",  LW'(full),     LW'(0));
      chk("rst_ready", LW'(wb_ready), LW'(1));
      chk("rst_hit",   LW'(lk_hit),   LW'(0));
      chk("rst_done",  LW'(fdone),    LW'(0));
    end else begin
      sz = mq.size();
      wl = wb_addr[AW-1:OFF];
      ll = lk_addr[AW-1:OFF];
      mi = -1;
      li = -1;
      for (int i = 0; i < sz; i++) begin
        if (!(i == 0 && m_issuing) && mq[i].line == wl) mi = i;
        if (!(i == 0 && m_issuing) && mq[i].line == ll) li = i;
      end
      if (li < 0 && m_issuing && mq[0].line == ll) li = 0;
      ex_ready = (mi >= 0) || (sz < DEPTH && !flush);
      ex_done  = flush && sz == 0 && m_armed;

      chk("count", LW'(count),    LW'(sz));
      chk("full",  LW'(full),     LW'(sz == DEPTH));
      chk("empty", LW'(empty),    LW'(sz == 0));
      chk("ready", LW'(wb_ready), LW'(ex_ready));
      chk("fdone", LW'(fdone),    LW'(ex_done));
      chk("able",  LW'(able),     LW'(m_issuing));
      if (m_issuing) begin
        m = bmask(mq[0].strb);
        chk("wr_addr", LW'(wr_addr), LW'({mq[0].line, 5'b0}));
        chk("wr_strb", LW'(wr_strb), LW'(mq[0].strb));
        chk("wr_data", wr_data & m,  mq[0].data & m);
      end
      chk("lk_hit", LW'(lk_hit), LW'(li >= 0));
      if (li >= 0) begin
        m = bmask(mq[li].strb);
        chk("lk_strb", LW'(lk_strb), LW'(mq[li].strb));
        chk("lk_data", lk_data & m,  mq[li].data & m);
      end else begin
        chk("lk_strb_miss", LW'(lk_strb), LW'(0));
        chk("lk_data_miss", lk_data,      LW'(0));
      end

      if (wb_valid && mi >= 0) begin
        e = mq[mi];
        m = bmask(wb_strb);
        e.data = (e.data & ~m) | (wb_data & m);
        e.strb = e.strb | wb_strb;
        mq[mi] = e;
      end
      if (m_issuing && hs) begin
        void'(mq.pop_front());
        m_issuing = 0;
      end else if (!m_issuing && sz > 0) begin
        m_issuing = 1;
      end
      if (wb_valid && mi < 0 && sz < DEPTH && !flush && wb_strb != 0) begin
        e.line = wl;
        e.data = wb_data & bmask(wb_strb);
        e.strb = wb_strb;
        mq.push_back(e);
      end
      if (!flush)       m_armed = 1;
      else if (ex_done) m_armed = 0;
    end
  end

  always @(negedge clk) if (!rst && fdone) done_cnt++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [LB-1:0] s, input logic [LW-1:0] d);
    wb_valid = 1'b1;
    wb_addr  = a;
    wb_strb  = s;
    wb_data  = d;
    step();
    wb_valid = 1'b0;
    wb_strb  = '0;
  endtask

  task automatic drain_all();
    hs = 1'b1;
    for (int k = 0; k < 80 && !empty; k++) step();
    chk("drain_done", LW'(empty), LW'(1));
    hs = 1'b0;
  endtask

  task automatic wait_able();
    for (int k = 0; k < 20 && !able; k++) step();
    chk("able_wait", LW'(able), LW'(1));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [AW-1:0] got [3];
    wb_valid = 0; wb_addr = 0; wb_data = 0; wb_strb = 0;
    hs = 0; lk_addr = 0; flush = 0;
    got[0] = 0; got[1] = 0; got[2] = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("t0_empty", LW'(empty),    LW'(1));
    chk("t0_ready", LW'(wb_ready), LW'(1));
    rst = 1'b0;
    step();

    // Single write: count first, write request one cycle later.
    wr(32'h1000, 32'hFFFF_FFFF, {8{32'hA5A5_0001}});
    #2;
    chk("t1_count", LW'(count), LW'(1));
    chk("t1_able0", LW'(able),  LW'(0));
    step();
    #2;
    chk("t1_able1", LW'(able),    LW'(1));
    chk("t1_addr",  LW'(wr_addr), LW'(32'h1000));

    // Same line while draining: new entry, then a merge into it.
    wr(32'h1004, 32'h0000_000F, {32{8'h11}});
    lk_addr = 32'h1000;
    #2;
    chk("t5_hit",    LW'(lk_hit),  LW'(1));
    chk("t5_lkstrb", LW'(lk_strb), LW'(32'h0000_000F));
    chk("t2_count1", LW'(count),   LW'(2));
    wr(32'h1008, 32'h0000_00F0, {32{8'h22}});
    #2;
    chk("t2_lkstrb", LW'(lk_strb),       LW'(32'h0000_00FF));
    chk("t2_lkdata", LW'(lk_data[63:0]), LW'(64'h2222_2222_1111_1111));
    chk("t2_count2", LW'(count),         LW'(2));
    chk("t2_wrstrb", LW'(wr_strb),       LW'(32'hFFFF_FFFF));
    drain_all();

    // Fill to full, then new line refused and merge accepted.
    for (int i = 0; i < 8; i++) wr(32'h2000 + 32'(i) * 32, 32'hFFFF_FFFF, {8{$urandom}});
    #2;
    chk("t3_full",  LW'(full),  LW'(1));
    chk("t3_count", LW'(count), LW'(8));
    wb_valid = 1'b1; wb_addr = 32'h3000; wb_strb = 32'h1; wb_data = {8{$urandom}};
    #1;
    chk("t3_ready_new", LW'(wb_ready), LW'(0));
    step();
    wb_addr = 32'h2020;
    #1;
    chk("t3_ready_merge", LW'(wb_ready), LW'(1));
    step();
    wb_valid = 1'b0; wb_strb = '0;

    // Retire once, then allocate and retire in the same cycle.
    wait_able();
    hs = 1'b1;
    step();
    hs = 1'b0;
    #1;
    chk("t4_count7", LW'(count), LW'(7));
    wait_able();
    hs = 1'b1;
    wr(32'h3000, 32'hFFFF_FFFF, {8{$urandom}});
    hs = 1'b0;
    #1;
    chk("t4_count_stable", LW'(count), LW'(7));
    chk("t4_not_full",     LW'(full),  LW'(0));
    drain_all();

    // Randomized traffic over a small set of lines.
    for (int c = 0; c < 600; c++) begin
      wb_valid = 1'($urandom_range(0, 1));
      wb_addr  = 32'h4000 + 32'($urandom_range(0, 11)) * 32 + 32'($urandom_range(0, 31));
      wb_strb  = ($urandom_range(0, 7) == 0) ? 32'h0 : 32'($urandom);
      wb_data  = {8{$urandom}};
      hs       = (c < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 39) == 0) flush = ~flush;
      lk_addr  = 32'h4000 + 32'($urandom_range(0, 12)) * 32;
      step();
    end
    wb_valid = 1'b0; wb_strb = '0; flush = 1'b0;
    drain_all();
    step();

    // Flush with three entries: in-order writes and a single done pulse.
    wr(32'h5000, 32'hFFFF_FFFF, {8{$urandom}});
    wr(32'h5020, 32'hFFFF_FFFF, {8{$urandom}});
    wr(32'h5040, 32'hFFFF_FFFF, {8{$urandom}});
    done_cnt = 0;
    flush = 1'b1;
    n = 0;
    for (int k = 0; k < 30; k++) begin
      if (able) begin
        if (n < 3) got[n] = wr_addr;
        n++;
        hs = 1'b1;
      end else begin
        hs = 1'b0;
      end
      step();
    end
    hs = 1'b0;
    chk("t6_nwrites", LW'(n),      LW'(3));
    chk("t6_order0",  LW'(got[0]), LW'(32'h5000));
    chk("t6_order1",  LW'(got[1]), LW'(32'h5020));
    chk("t6_order2",  LW'(got[2]), LW'(32'h5040));
    chk("t6_done1",   LW'(done_cnt), LW'(1));
    flush = 1'b0;
    step();
    step();
    flush = 1'b1;
    repeat (3) step();
    chk("t6_done_empty", LW'(done_cnt), LW'(2));
    flush = 1'b0;
    step();

    // Asynchronous reset in the middle of a drain.
    wr(32'h6000, 32'hFFFF_FFFF, {8{$urandom}});
    wr(32'h6020, 32'hFFFF_FFFF, {8{$urandom}});
    lk_addr = 32'h6000;
    wait_able();
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_able",  LW'(able),   LW'(0));
    chk("t6_rst_count", LW'(count),  LW'(0));
    chk("t6_rst_empty", LW'(empty),  LW'(1));
    chk("t6_rst_hit",   LW'(lk_hit), LW'(0));
    step();
    rst = 1'b0;
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
